// File: rtl/axi_arb_pkg.sv
// Shared types and widths for the two-master AXI read arbiter.
package axi_arb_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned ID_W   = 4;
    localparam int unsigned LEN_W  = 8;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StAddr = 2'd1,
        StData = 2'd2
    } arb_state_e;

endpackage

// File: rtl/axi_rr_arb2.sv
// Two-way request picker: round-robin on ties, or fixed priority to req[1] when mode is set.
module axi_rr_arb2
    import axi_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_grant,
    input  logic       mode,
    output logic       grant
);

    always_comb begin
        grant = req[1];
        if (req == 2'b11) begin
            grant = mode ? 1'b1 : ~last_grant;
        end
    end

endmodule

// File: rtl/axi_rd_arbiter.sv
// Merges the icache (inport0) and dcache (inport1) AXI read masters onto one memory read port,
// one burst in flight at a time.
module axi_rd_arbiter
    import axi_arb_pkg::*;
#(
    parameter int unsigned ARB_MODE = 0
) (
    input  logic              clk_i,
    input  logic              rst_i,

    input  logic              inport0_arvalid_i,
    input  logic [ADDR_W-1:0] inport0_araddr_i,
    input  logic [ID_W-1:0]   inport0_arid_i,
    input  logic [LEN_W-1:0]  inport0_arlen_i,
    input  logic [1:0]        inport0_arburst_i,
    input  logic              inport0_rready_i,
    output logic              inport0_arready_o,
    output logic              inport0_rvalid_o,
    output logic [DATA_W-1:0] inport0_rdata_o,
    output logic [1:0]        inport0_rresp_o,
    output logic [ID_W-1:0]   inport0_rid_o,
    output logic              inport0_rlast_o,

    input  logic              inport1_arvalid_i,
    input  logic [ADDR_W-1:0] inport1_araddr_i,
    input  logic [ID_W-1:0]   inport1_arid_i,
    input  logic [LEN_W-1:0]  inport1_arlen_i,
    input  logic [1:0]        inport1_arburst_i,
    input  logic              inport1_rready_i,
    output logic              inport1_arready_o,
    output logic              inport1_rvalid_o,
    output logic [DATA_W-1:0] inport1_rdata_o,
    output logic [1:0]        inport1_rresp_o,
    output logic [ID_W-1:0]   inport1_rid_o,
    output logic              inport1_rlast_o,

    output logic              outport_arvalid_o,
    output logic [ADDR_W-1:0] outport_araddr_o,
    output logic [ID_W-1:0]   outport_arid_o,
    output logic [LEN_W-1:0]  outport_arlen_o,
    output logic [1:0]        outport_arburst_o,
    output logic              outport_rready_o,
    input  logic              outport_arready_i,
    input  logic              outport_rvalid_i,
    input  logic [DATA_W-1:0] outport_rdata_i,
    input  logic [1:0]        outport_rresp_i,
    input  logic [ID_W-1:0]   outport_rid_i,
    input  logic              outport_rlast_i,

    output logic              proto_err_o
);

    arb_state_e       state_q;
    logic             owner_q;
    logic             last_grant_q;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] beat_q;
    logic             proto_err_q;

    logic             grant;
    logic             own_arvalid;
    logic [LEN_W-1:0] own_arlen;
    logic             own_rready;
    logic             ar_hs;
    logic             r_hs;

    axi_rr_arb2 u_pick (
        .req        ({inport1_arvalid_i, inport0_arvalid_i}),
        .last_grant (last_grant_q),
        .mode       (ARB_MODE == 1),
        .grant      (grant)
    );

    always_comb begin
        own_arvalid       = owner_q ? inport1_arvalid_i : inport0_arvalid_i;
        own_arlen         = owner_q ? inport1_arlen_i   : inport0_arlen_i;
        own_rready        = owner_q ? inport1_rready_i  : inport0_rready_i;
        outport_araddr_o  = owner_q ? inport1_araddr_i  : inport0_araddr_i;
        outport_arid_o    = owner_q ? inport1_arid_i    : inport0_arid_i;
        outport_arburst_o = owner_q ? inport1_arburst_i : inport0_arburst_i;
        outport_arlen_o   = own_arlen;
    end

    always_comb begin
        outport_arvalid_o = (state_q == StAddr) && own_arvalid;
        inport0_arready_o = (state_q == StAddr) && !owner_q && outport_arready_i;
        inport1_arready_o = (state_q == StAddr) &&  owner_q && outport_arready_i;
        outport_rready_o  = (state_q == StData) && own_rready;
        inport0_rvalid_o  = (state_q == StData) && !owner_q && outport_rvalid_i;
        inport1_rvalid_o  = (state_q == StData) &&  owner_q && outport_rvalid_i;
        ar_hs             = outport_arvalid_o && outport_arready_i;
        r_hs              = outport_rvalid_i && outport_rready_o;
    end

    // R payload fans out to both ports; only the owner's rvalid qualifies it.
    always_comb begin
        inport0_rdata_o = outport_rdata_i;
        inport0_rresp_o = outport_rresp_i;
        inport0_rid_o   = outport_rid_i;
        inport0_rlast_o = outport_rlast_i;
        inport1_rdata_o = outport_rdata_i;
        inport1_rresp_o = outport_rresp_i;
        inport1_rid_o   = outport_rid_i;
        inport1_rlast_o = outport_rlast_i;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= StIdle;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
            len_q        <= '0;
            beat_q       <= '0;
            proto_err_q  <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (inport0_arvalid_i || inport1_arvalid_i) begin
                        owner_q <= grant;
                        state_q <= StAddr;
                    end
                end
                StAddr: begin
                    if (ar_hs) begin
                        len_q   <= own_arlen;
                        beat_q  <= '0;
                        state_q <= StData;
                    end
                end
                StData: begin
                    if (r_hs) begin
                        beat_q <= beat_q + LEN_W'(1);
                        // rlast must coincide exactly with the final counted beat
                        if (outport_rlast_i != (beat_q == len_q)) begin
                            proto_err_q <= 1'b1;
                        end
                        if (outport_rlast_i) begin
                            last_grant_q <= owner_q;
                            state_q      <= StIdle;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign proto_err_o = proto_err_q;

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Self-checking bench for axi_rd_arbiter: scoreboard queues for AR and R traffic.
module tb_axi_rd_arbiter;

    localparam logic [3:0] ID0 = 4'h1;
    localparam logic [3:0] ID1 = 4'h2;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        inport0_arvalid_i, inport1_arvalid_i;
    logic [31:0] inport0_araddr_i, inport1_araddr_i;
    logic [3:0]  inport0_arid_i, inport1_arid_i;
    logic [7:0]  inport0_arlen_i, inport1_arlen_i;
    logic [1:0]  inport0_arburst_i, inport1_arburst_i;
    logic        inport0_rready_i, inport1_rready_i;
    logic        inport0_arready_o, inport1_arready_o;
    logic        inport0_rvalid_o, inport1_rvalid_o;
    logic [31:0] inport0_rdata_o, inport1_rdata_o;
    logic [1:0]  inport0_rresp_o, inport1_rresp_o;
    logic [3:0]  inport0_rid_o, inport1_rid_o;
    logic        inport0_rlast_o, inport1_rlast_o;
    logic        outport_arvalid_o, outport_rready_o;
    logic [31:0] outport_araddr_o;
    logic [3:0]  outport_arid_o;
    logic [7:0]  outport_arlen_o;
    logic [1:0]  outport_arburst_o;
    logic        outport_arready_i, outport_rvalid_i, outport_rlast_i;
    logic [31:0] outport_rdata_i;
    logic [1:0]  outport_rresp_i;
    logic [3:0]  outport_rid_i;
    logic        proto_err_o;

    // Fixed-priority instance shares all inputs with the round-robin DUT.
    logic        f_arready0, f_arready1, f_rvalid0, f_rvalid1, f_rlast0, f_rlast1;
    logic [31:0] f_rdata0, f_rdata1, f_araddr;
    logic [1:0]  f_rresp0, f_rresp1, f_arburst;
    logic [3:0]  f_rid0, f_rid1, f_arid;
    logic [7:0]  f_arlen;
    logic        f_arvalid, f_rready, f_proto_err;

    always #5 clk_i = ~clk_i;

    axi_rd_arbiter #(.ARB_MODE(0)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .inport0_arvalid_i(inport0_arvalid_i), .inport0_araddr_i(inport0_araddr_i),
        .inport0_arid_i(inport0_arid_i), .inport0_arlen_i(inport0_arlen_i),
        .inport0_arburst_i(inport0_arburst_i), .inport0_rready_i(inport0_rready_i),
        .inport0_arready_o(inport0_arready_o), .inport0_rvalid_o(inport0_rvalid_o),
        .inport0_rdata_o(inport0_rdata_o), .inport0_rresp_o(inport0_rresp_o),
        .inport0_rid_o(inport0_rid_o), .inport0_rlast_o(inport0_rlast_o),
        .inport1_arvalid_i(inport1_arvalid_i), .inport1_araddr_i(inport1_araddr_i),
        .inport1_arid_i(inport1_arid_i), .inport1_arlen_i(inport1_arlen_i),
        .inport1_arburst_i(inport1_arburst_i), .inport1_rready_i(inport1_rready_i),
        .inport1_arready_o(inport1_arready_o), .inport1_rvalid_o(inport1_rvalid_o),
        .inport1_rdata_o(inport1_rdata_o), .inport1_rresp_o(inport1_rresp_o),
        .inport1_rid_o(inport1_rid_o), .inport1_rlast_o(inport1_rlast_o),
        .outport_arvalid_o(outport_arvalid_o), .outport_araddr_o(outport_araddr_o),
        .outport_arid_o(outport_arid_o), .outport_arlen_o(outport_arlen_o),
        .outport_arburst_o(outport_arburst_o), .outport_rready_o(outport_rready_o),
        .outport_arready_i(outport_arready_i), .outport_rvalid_i(outport_rvalid_i),
        .outport_rdata_i(outport_rdata_i), .outport_rresp_i(outport_rresp_i),
        .outport_rid_i(outport_rid_i), .outport_rlast_i(outport_rlast_i),
        .proto_err_o(proto_err_o)
    );

    axi_rd_arbiter #(.ARB_MODE(1)) dut_fp (
        .clk_i(clk_i), .rst_i(rst_i),
        .inport0_arvalid_i(inport0_arvalid_i), .inport0_araddr_i(inport0_araddr_i),
        .inport0_arid_i(inport0_arid_i), .inport0_arlen_i(inport0_arlen_i),
        .inport0_arburst_i(inport0_arburst_i), .inport0_rready_i(inport0_rready_i),
        .inport0_arready_o(f_arready0), .inport0_rvalid_o(f_rvalid0),
        .inport0_rdata_o(f_rdata0), .inport0_rresp_o(f_rresp0),
        .inport0_rid_o(f_rid0), .inport0_rlast_o(f_rlast0),
        .inport1_arvalid_i(inport1_arvalid_i), .inport1_araddr_i(inport1_araddr_i),
        .inport1_arid_i(inport1_arid_i), .inport1_arlen_i(inport1_arlen_i),
        .inport1_arburst_i(inport1_arburst_i), .inport1_rready_i(inport1_rready_i),
        .inport1_arready_o(f_arready1), .inport1_rvalid_o(f_rvalid1),
        .inport1_rdata_o(f_rdata1), .inport1_rresp_o(f_rresp1),
        .inport1_rid_o(f_rid1), .inport1_rlast_o(f_rlast1),
        .outport_arvalid_o(f_arvalid), .outport_araddr_o(f_araddr),
        .outport_arid_o(f_arid), .outport_arlen_o(f_arlen),
        .outport_arburst_o(f_arburst), .outport_rready_o(f_rready),
        .outport_arready_i(outport_arready_i), .outport_rvalid_i(outport_rvalid_i),
        .outport_rdata_i(outport_rdata_i), .outport_rresp_i(outport_rresp_i),
        .outport_rid_i(outport_rid_i), .outport_rlast_i(outport_rlast_i),
        .proto_err_o(f_proto_err)
    );

    typedef struct packed {
        logic        port;
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
    } beat_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  id;
        logic [7:0]  len;
        logic [1:0]  burst;
    } ar_t;

    beat_t r_q[$];
    ar_t   ar_q[$];
    int    n_checks = 0;
    int    n_errs   = 0;
    int    fp_seen  = 0;
    bit    fp_chk   = 1'b0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic pop_beat(input logic port, input beat_t got);
        beat_t e;
        if (r_q.size() == 0) begin
            check_val("r_unexpected", {63'd0, port}, 64'hdead);
        end else begin
            e = r_q.pop_front();
            check_val("r_beat", 64'(got), 64'(e));
        end
    endtask

    // Output monitor: R beats and AR handshakes against the scoreboard.
    always @(negedge clk_i) begin
        ar_t ea;
        if (inport0_rvalid_o && inport0_rready_i) begin
            pop_beat(1'b0, '{port: 1'b0, data: inport0_rdata_o, resp: inport0_rresp_o,
                             last: inport0_rlast_o});
        end
        if (inport1_rvalid_o && inport1_rready_i) begin
            pop_beat(1'b1, '{port: 1'b1, data: inport1_rdata_o, resp: inport1_rresp_o,
                             last: inport1_rlast_o});
        end
        if (outport_arvalid_o && outport_arready_i) begin
            if (ar_q.size() == 0) begin
                check_val("ar_unexpected", {32'd0, outport_araddr_o}, 64'hdead);
            end else begin
                ea = ar_q.pop_front();
                check_val("ar_fields", 64'({outport_araddr_o, outport_arid_o, outport_arlen_o,
                                            outport_arburst_o}), 64'(ea));
            end
        end
        if (fp_chk && f_arvalid && outport_arready_i) begin
            fp_seen++;
            check_val("fp_grant_id", 64'(f_arid), 64'(ID1));
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Waits for an AR handshake on either port; drops that port's arvalid unless keep.
    task automatic wait_ar(output int port, output int cycles, input bit keep);
        port   = -1;
        cycles = 0;
        while (port < 0 && cycles < 20) begin
            @(negedge clk_i);
            if (inport0_arvalid_i && inport0_arready_o) port = 0;
            else if (inport1_arvalid_i && inport1_arready_o) port = 1;
            tick();
            cycles++;
        end
        if (port < 0) begin
            check_val("ar_timeout", 64'd0, 64'd1);
        end else if (!keep) begin
            if (port == 0) inport0_arvalid_i = 1'b0;
            else inport1_arvalid_i = 1'b0;
        end
    endtask

    task automatic send_beats(input logic port, input int n, input int last_at, input int err_at,
                              input bit toggle, input logic [31:0] base);
        int   i = 0;
        int   cyc = 0;
        logic rdy;
        while (i < n && cyc < 100) begin
            rdy              = !(toggle && (cyc % 2 == 1));
            outport_rvalid_i = 1'b1;
            outport_rdata_i  = base + 32'(i);
            outport_rresp_i  = (i == err_at) ? 2'b10 : 2'b00;
            outport_rid_i    = port ? ID1 : ID0;
            outport_rlast_i  = (i == last_at);
            inport0_rready_i = port ? 1'b1 : rdy;
            inport1_rready_i = port ? rdy : 1'b1;
            if (rdy) begin
                r_q.push_back('{port: port, data: outport_rdata_i, resp: outport_rresp_i,
                                last: outport_rlast_i});
            end
            @(negedge clk_i);
            check_val("rready_mirror", 64'(outport_rready_o), 64'(rdy));
            check_val("nonowner_rvalid", 64'(port ? inport0_rvalid_o : inport1_rvalid_o), 64'd0);
            tick();
            if (rdy) i++;
            cyc++;
        end
        outport_rvalid_i = 1'b0;
        outport_rlast_i  = 1'b0;
        inport0_rready_i = 1'b1;
        inport1_rready_i = 1'b1;
    endtask

    initial begin
        int p;
        int c;
        rst_i             = 1'b1;
        inport0_arvalid_i = 1'b0; inport1_arvalid_i = 1'b0;
        inport0_araddr_i  = '0;   inport1_araddr_i  = '0;
        inport0_arid_i    = ID0;  inport1_arid_i    = ID1;
        inport0_arlen_i   = '0;   inport1_arlen_i   = '0;
        inport0_arburst_i = 2'b01; inport1_arburst_i = 2'b01;
        inport0_rready_i  = 1'b1; inport1_rready_i  = 1'b1;
        outport_arready_i = 1'b1; outport_rvalid_i  = 1'b0;
        outport_rdata_i   = '0;   outport_rresp_i   = '0;
        outport_rid_i     = '0;   outport_rlast_i   = 1'b0;
        repeat (3) tick();
        rst_i = 1'b0;
        @(negedge clk_i);
        check_val("rst_handshakes", 64'({inport0_arready_o, inport1_arready_o, inport0_rvalid_o,
                  inport1_rvalid_o, outport_arvalid_o, outport_rready_o}), 64'd0);
        check_val("rst_proto_err", 64'(proto_err_o), 64'd0);
        tick();

        // Single requester, 8-beat burst; one-cycle arbitration bubble.
        inport0_arvalid_i = 1'b1;
        inport0_araddr_i  = 32'h8000_0000;
        inport0_arlen_i   = 8'd7;
        ar_q.push_back('{addr: 32'h8000_0000, id: ID0, len: 8'd7, burst: 2'b01});
        @(negedge clk_i);
        check_val("ar_bubble", 64'(outport_arvalid_o), 64'd0);
        tick();
        wait_ar(p, c, 1'b0);
        check_val("ar_port_single", 64'(p), 64'd0);
        check_val("ar_latency", 64'(c), 64'd1);
        send_beats(1'b0, 8, 7, -1, 1'b0, 32'h0000_1000);
        @(negedge clk_i);
        check_val("idle_after_last", 64'(outport_arvalid_o || outport_rready_o), 64'd0);
        check_val("perr_clean_burst", 64'(proto_err_o), 64'd0);
        tick();

        // AR stall with both requesting: port1 owns (round-robin after port0).
        outport_arready_i = 1'b0;
        inport0_arvalid_i = 1'b1; inport0_araddr_i = 32'h0000_3000; inport0_arlen_i = 8'd0;
        inport1_arvalid_i = 1'b1; inport1_araddr_i = 32'h0000_2000; inport1_arlen_i = 8'd1;
        tick();
        for (int k = 0; k < 5; k++) begin
            @(negedge clk_i);
            check_val("stall_arready", 64'({inport0_arready_o, inport1_arready_o}), 64'd0);
            check_val("stall_fields", 64'({outport_arvalid_o, outport_araddr_o, outport_arid_o}),
                      64'({1'b1, 32'h0000_2000, ID1}));
            tick();
        end
        outport_arready_i = 1'b1;
        ar_q.push_back('{addr: 32'h0000_2000, id: ID1, len: 8'd1, burst: 2'b01});
        wait_ar(p, c, 1'b0);
        check_val("stall_owner", 64'(p), 64'd1);
        send_beats(1'b1, 2, 1, -1, 1'b0, 32'h0000_2000);
        ar_q.push_back('{addr: 32'h0000_3000, id: ID0, len: 8'd0, burst: 2'b01});
        wait_ar(p, c, 1'b0);
        check_val("nonowner_later", 64'(p), 64'd0);
        send_beats(1'b0, 1, 0, -1, 1'b0, 32'h0000_3000);

        // Toggled rready with an SLVERR beat; only handshakes advance the beat count.
        inport1_arvalid_i = 1'b1; inport1_araddr_i = 32'h0000_5000; inport1_arlen_i = 8'd3;
        ar_q.push_back('{addr: 32'h0000_5000, id: ID1, len: 8'd3, burst: 2'b01});
        wait_ar(p, c, 1'b0);
        send_beats(1'b1, 4, 3, 1, 1'b1, 32'h0000_5000);
        @(negedge clk_i);
        check_val("perr_toggle", 64'(proto_err_o), 64'd0);
        tick();

        // Early rlast: arlen 3, rlast on beat 2.
        inport0_arvalid_i = 1'b1; inport0_araddr_i = 32'h0000_4000; inport0_arlen_i = 8'd3;
        ar_q.push_back('{addr: 32'h0000_4000, id: ID0, len: 8'd3, burst: 2'b01});
        wait_ar(p, c, 1'b0);
        send_beats(1'b0, 3, 2, -1, 1'b0, 32'h0000_4000);
        @(negedge clk_i);
        check_val("perr_set", 64'(proto_err_o), 64'd1);
        repeat (3) tick();
        @(negedge clk_i);
        check_val("perr_held", 64'(proto_err_o), 64'd1);
        tick();

        // Reset during beat 3 of an 8-beat burst.
        inport0_arvalid_i = 1'b1; inport0_araddr_i = 32'h0000_6000; inport0_arlen_i = 8'd7;
        ar_q.push_back('{addr: 32'h0000_6000, id: ID0, len: 8'd7, burst: 2'b01});
        wait_ar(p, c, 1'b0);
        send_beats(1'b0, 3, -1, -1, 1'b0, 32'h0000_6000);
        outport_rvalid_i = 1'b1;
        outport_rdata_i  = 32'h0000_6003;
        outport_rresp_i  = 2'b00;
        outport_rlast_i  = 1'b0;
        r_q.push_back('{port: 1'b0, data: 32'h0000_6003, resp: 2'b00, last: 1'b0});
        rst_i = 1'b1;
        tick();
        rst_i            = 1'b0;
        outport_rvalid_i = 1'b0;
        @(negedge clk_i);
        check_val("rst_mid_valids", 64'({inport0_arready_o, inport1_arready_o, inport0_rvalid_o,
                  inport1_rvalid_o, outport_arvalid_o, outport_rready_o}), 64'd0);
        check_val("rst_mid_perr", 64'(proto_err_o), 64'd0);
        tick();

        // Continuous requests from both: 0,1,0,1 round-robin; fixed-priority DUT always picks 1.
        fp_chk = 1'b1;
        inport0_arvalid_i = 1'b1; inport0_araddr_i = 32'h0000_7000; inport0_arlen_i = 8'd1;
        inport1_arvalid_i = 1'b1; inport1_araddr_i = 32'h0000_8000; inport1_arlen_i = 8'd1;
        for (int k = 0; k < 4; k++) begin
            if (k % 2 == 0) ar_q.push_back('{addr: 32'h0000_7000, id: ID0, len: 8'd1, burst: 2'b01});
            else ar_q.push_back('{addr: 32'h0000_8000, id: ID1, len: 8'd1, burst: 2'b01});
            wait_ar(p, c, 1'b1);
            check_val("rr_grant", 64'(p), 64'(k % 2));
            send_beats(p[0], 2, 1, -1, 1'b0, 32'h0000_9000 + 32'(k * 16));
        end
        fp_chk = 1'b0;
        inport0_arvalid_i = 1'b0;
        inport1_arvalid_i = 1'b0;
        repeat (2) tick();
        check_val("fp_grants_seen", 64'(fp_seen), 64'd4);
        check_val("r_q_drained", 64'(r_q.size()), 64'd0);
        check_val("ar_q_drained", 64'(ar_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
        $finish;
    end

endmodule
